// File: rtl/mac_pipe_pkg.sv
// Shared definitions for the pipelined multiply-accumulate unit:
// opcode encodings, the stage-kind tag and the accumulator width helper.
package mac_pkg;

  localparam logic [3:0] MAC_RESET = 4'h0;
  localparam logic [3:0] MAC_MULT  = 4'h1;
  localparam logic [3:0] MAC_ACC   = 4'h2;
  localparam logic [3:0] MAC_MACC  = 4'h3;
  localparam logic [3:0] MAC_REGA  = 4'h4;
  localparam logic [3:0] MAC_REGB  = 4'h5;
  localparam logic [3:0] MAC_MSW   = 4'h6;
  localparam logic [3:0] MAC_LSW   = 4'h7;
  localparam logic [3:0] MAC_GRD   = 4'h8;
  localparam logic [3:0] MAC_NOOP  = 4'hF;

  // What an in-flight product is destined for once it leaves stage 1.
  typedef enum logic {
    KIND_MULT = 1'b0,  // product lands in registerC
    KIND_MACC = 1'b1   // product is added into the accumulator
  } stage_kind_e;

  // Accumulator width: full product plus guard bits.
  function automatic int acc_width(input int data_width, input int guard_bits);
    return 2 * data_width + guard_bits;
  endfunction

endpackage

// File: rtl/mac_pipe_if.sv
// Operation/readout bundle between the processor controller (master) and
// the MAC unit (slave).
//
// Handshake: an operation transfers on a rising clk edge where op_valid and
// op_ready are both high. op_ready is combinational from opcode and the
// pipeline state and may be low for hazards; the master holds opcode,
// signed_mode and data_in stable while op_valid is high and not yet accepted.
// data_valid is a one-cycle pulse qualifying a new data_out; there is no
// back-pressure on the readout path.
interface mac_pipe_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  op_valid;
  logic                  op_ready;
  logic [3:0]            opcode;
  logic                  signed_mode;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  acc_overflow;
  logic                  busy;

  modport master (
    output op_valid, opcode, signed_mode, data_in,
    input  op_ready, data_out, data_valid, acc_overflow, busy
  );

  modport slave (
    input  op_valid, opcode, signed_mode, data_in,
    output op_ready, data_out, data_valid, acc_overflow, busy
  );

endinterface

// File: rtl/mac_pipe_sat_add.sv
// Combinational accumulator adder: extends the product to the accumulator
// width, adds, detects overflow and optionally clamps the result.
module mac_sat_add #(
  parameter int ACC_W    = 20,
  parameter int PROD_W   = 16,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              signed_mode,
  output logic [ACC_W-1:0]  sum_out,
  output logic              overflow
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   raw_sum;

  // Extend, add on ACC_W+1 bits, flag overflow, clamp when saturating.
  always_comb begin
    prod_ext = signed_mode ? {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in}
                           : {{(ACC_W-PROD_W){1'b0}}, prod_in};
    raw_sum  = {1'b0, acc_in} + {1'b0, prod_ext};

    if (signed_mode) begin
      overflow = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
                 (raw_sum[ACC_W-1] != acc_in[ACC_W-1]);
    end else begin
      overflow = raw_sum[ACC_W];
    end

    sum_out = raw_sum[ACC_W-1:0];
    if (overflow && (SATURATE != 0)) begin
      if (!signed_mode) begin
        sum_out = '1;
      end else if (acc_in[ACC_W-1]) begin
        // Both operands negative: clamp to the most negative value.
        sum_out = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum_out = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate unit. Stage 1 holds the freshly computed
// product; at the following edge it either lands in registerC (MULT) or is
// accumulated (MACC). Stage 2 marks the cycle after write-back so readouts
// and ACC wait until the pipeline has fully drained. ACC and the readouts
// act on the accumulator directly at their acceptance edge.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GUARD_BITS = 4,
  parameter int SATURATE   = 1
) (
  input  logic       clk,
  input  logic       a_reset_n,
  mac_pipe_if.slave  bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = acc_width(DATA_WIDTH, GUARD_BITS);

  // Operand and pipeline state.
  logic [DW-1:0]    reg_a;
  logic [DW-1:0]    reg_b;
  logic [PW-1:0]    prod_s1;
  logic             s1_v;
  stage_kind_e      s1_kind;
  logic             s1_sgn;
  logic             s2_v;
  stage_kind_e      s2_kind;
  logic             acc_v;
  logic [PW-1:0]    reg_c;
  logic             c_signed;

  // Accumulator and readout state.
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;
  logic             last_signed;
  logic [DW-1:0]    data_out_q;
  logic             data_valid_q;

  // Combinational helpers.
  logic             ready;
  logic             accept;
  logic             do_reset;
  logic             macc_inflight;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod_next;
  logic             macc_wb;
  logic             acc_take;
  logic             add_en;
  logic [PW-1:0]    add_prod;
  logic             add_sgn;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [DW-1:0]    grd_word;

  assign accept        = bus.op_valid && ready;
  assign do_reset      = accept && (bus.opcode == MAC_RESET);
  assign macc_inflight = (s1_v && (s1_kind == KIND_MACC)) ||
                         (s2_v && (s2_kind == KIND_MACC));

  // Hazard check: ACC waits for all products, readouts wait for MACC/ACC.
  always_comb begin
    ready = 1'b1;
    case (bus.opcode)
      MAC_ACC:                   ready = !(s1_v || s2_v);
      MAC_MSW, MAC_LSW, MAC_GRD: ready = !(macc_inflight || acc_v);
      default:                   ready = 1'b1;
    endcase
  end

  // One multiplier for both modes: the low PW bits of a PW x PW product of
  // the sign- or zero-extended operands are the correct result either way.
  always_comb begin
    a_ext     = bus.signed_mode ? {{DW{reg_a[DW-1]}}, reg_a} : {{DW{1'b0}}, reg_a};
    b_ext     = bus.signed_mode ? {{DW{reg_b[DW-1]}}, reg_b} : {{DW{1'b0}}, reg_b};
    prod_next = a_ext * b_ext;
  end

  // Only one accumulate source can be active per edge: ACC stalls while any
  // product is in flight, so the MACC write-back and ACC never coincide.
  assign macc_wb  = s1_v && (s1_kind == KIND_MACC);
  assign acc_take = accept && (bus.opcode == MAC_ACC);
  assign add_en   = macc_wb || acc_take;
  assign add_prod = macc_wb ? prod_s1 : reg_c;
  assign add_sgn  = macc_wb ? s1_sgn : c_signed;

  mac_sat_add #(
    .ACC_W    (ACC_W),
    .PROD_W   (PW),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .acc_in      (acc),
    .prod_in     (add_prod),
    .signed_mode (add_sgn),
    .sum_out     (add_sum),
    .overflow    (add_ovf)
  );

  // Guard field readout, extended to a full word.
  always_comb begin
    grd_word = {DW{last_signed & acc[ACC_W-1]}};
    grd_word[GUARD_BITS-1:0] = acc[ACC_W-1:PW];
  end

  // Operand registers.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      reg_a <= '0;
      reg_b <= '0;
    end else if (accept) begin
      if (bus.opcode == MAC_REGA) reg_a <= bus.data_in;
      if (bus.opcode == MAC_REGB) reg_b <= bus.data_in;
    end
  end

  // Product pipeline and registerC; a RESET opcode kills every stage.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      prod_s1  <= '0;
      s1_v     <= 1'b0;
      s1_kind  <= KIND_MULT;
      s1_sgn   <= 1'b0;
      s2_v     <= 1'b0;
      s2_kind  <= KIND_MULT;
      acc_v    <= 1'b0;
      reg_c    <= '0;
      c_signed <= 1'b0;
    end else if (do_reset) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      acc_v    <= 1'b0;
      reg_c    <= '0;
      c_signed <= 1'b0;
    end else begin
      s2_v    <= s1_v;
      s2_kind <= s1_kind;
      s1_v    <= accept && ((bus.opcode == MAC_MULT) || (bus.opcode == MAC_MACC));
      if (accept && ((bus.opcode == MAC_MULT) || (bus.opcode == MAC_MACC))) begin
        prod_s1 <= prod_next;
        s1_kind <= (bus.opcode == MAC_MACC) ? KIND_MACC : KIND_MULT;
        s1_sgn  <= bus.signed_mode;
      end
      acc_v <= acc_take;
      if (s1_v && (s1_kind == KIND_MULT)) begin
        reg_c    <= prod_s1;
        c_signed <= s1_sgn;
      end
    end
  end

  // Accumulator and sticky overflow; RESET beats a same-edge write-back.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      acc         <= '0;
      acc_ovf     <= 1'b0;
      last_signed <= 1'b0;
    end else if (do_reset) begin
      acc         <= '0;
      acc_ovf     <= 1'b0;
      last_signed <= 1'b0;
    end else if (add_en) begin
      acc         <= add_sum;
      last_signed <= add_sgn;
      if (add_ovf) acc_ovf <= 1'b1;
    end
  end

  // Readout register with a one-cycle valid pulse; data_out holds otherwise.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (accept) begin
        case (bus.opcode)
          MAC_MSW: begin
            data_out_q   <= acc[PW-1:DW];
            data_valid_q <= 1'b1;
          end
          MAC_LSW: begin
            data_out_q   <= acc[DW-1:0];
            data_valid_q <= 1'b1;
          end
          MAC_GRD: begin
            data_out_q   <= grd_word;
            data_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.op_ready     = ready;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.acc_overflow = acc_ovf;
  assign bus.busy         = s1_v || s2_v || acc_v;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe (DW=8, GUARD=4, SATURATE=1): directed scenarios plus a
// randomized operation stream, checked against a sequential arithmetic model.
module tb_mac_pipe;
  import mac_pkg::*;

  localparam int  STALL_LIMIT = 20;
  localparam longint FULL     = 64'd1 << 20;
  localparam longint HALF     = 64'd1 << 19;

  logic clk;
  logic a_reset_n;

  mac_pipe_if #(.DATA_WIDTH(8)) bus ();

  mac_pipe #(
    .DATA_WIDTH (8),
    .GUARD_BITS (4),
    .SATURATE   (1)
  ) dut (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every readout pulse must match the oldest expected readout.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("data_valid_spurious", 32'(bus.data_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", 32'(bus.data_out), 32'(e));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Operations take effect in acceptance order; the hazards guarantee the
  // pipelined unit is indistinguishable from this sequential view.
  logic [7:0] m_a, m_b;
  longint     m_c;
  bit         m_c_sgn;
  longint     m_acc;      // accumulator bit pattern, 0 .. FULL-1
  bit         m_ovf;
  bit         m_last_sgn;
  logic [7:0] m_last_out;

  function automatic longint m_prod(input bit sgn);
    if (sgn) return longint'($signed(m_a)) * longint'($signed(m_b));
    return longint'(m_a) * longint'(m_b);
  endfunction

  task automatic m_add(input longint p, input bit sgn);
    longint v, lo, hi;
    if (sgn) begin
      v  = (m_acc >= HALF) ? m_acc - FULL : m_acc;
      lo = -HALF;
      hi = HALF - 1;
    end else begin
      v  = m_acc;
      lo = 0;
      hi = FULL - 1;
    end
    v = v + p;
    if (v > hi) begin m_ovf = 1; v = hi; end
    if (v < lo) begin m_ovf = 1; v = lo; end
    m_acc      = (v < 0) ? v + FULL : v;
    m_last_sgn = sgn;
  endtask

  task automatic m_reset_all();
    m_a = 0; m_b = 0; m_c = 0; m_c_sgn = 0;
    m_acc = 0; m_ovf = 0; m_last_sgn = 0; m_last_out = 0;
  endtask

  task automatic m_readout(input logic [7:0] v);
    exp_q.push_back(v);
    m_last_out = v;
  endtask

  task automatic m_apply(input logic [3:0] op, input bit sgn, input logic [7:0] d);
    longint g;
    case (op)
      MAC_RESET: begin m_acc = 0; m_c = 0; m_c_sgn = 0; m_ovf = 0; m_last_sgn = 0; end
      MAC_MULT:  begin m_c = m_prod(sgn); m_c_sgn = sgn; end
      MAC_ACC:   m_add(m_c, m_c_sgn);
      MAC_MACC:  m_add(m_prod(sgn), sgn);
      MAC_REGA:  m_a = d;
      MAC_REGB:  m_b = d;
      MAC_MSW:   m_readout(8'((m_acc >> 8) & 255));
      MAC_LSW:   m_readout(8'(m_acc & 255));
      MAC_GRD: begin
        g = (m_acc >> 16) & 15;
        if (m_last_sgn && g[3]) g = g | 'hF0;
        m_readout(8'(g));
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Presents one operation at a falling edge and holds it until accepted.
  task automatic do_op(input logic [3:0] op, input bit sgn, input logic [7:0] d,
                       output int stalls);
    int n;
    n = 0;
    bus.op_valid    = 1'b1;
    bus.opcode      = op;
    bus.signed_mode = sgn;
    bus.data_in     = d;
    #1;
    while (bus.op_ready !== 1'b1 && n < STALL_LIMIT) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      n++;
    end
    stalls = n;
    if (n >= STALL_LIMIT) begin
      check("op_ready_timeout", 32'(n), 32'(STALL_LIMIT - 1));
      bus.op_valid = 1'b0;
      bus.opcode   = MAC_NOOP;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    m_apply(op, sgn, d);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.opcode   = MAC_NOOP;
    if (op == MAC_MSW || op == MAC_LSW || op == MAC_GRD)
      check("acc_overflow", 32'(bus.acc_overflow), 32'(m_ovf));
  endtask

  task automatic op(input logic [3:0] o, input bit sgn, input logic [7:0] d);
    int s;
    do_op(o, sgn, d, s);
  endtask

  task automatic read_all();
    op(MAC_LSW, 0, 0);
    op(MAC_MSW, 0, 0);
    op(MAC_GRD, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int r;
    bit sgn;
    logic [3:0] o;

    bus.op_valid    = 1'b0;
    bus.opcode      = MAC_NOOP;
    bus.signed_mode = 1'b0;
    bus.data_in     = '0;
    a_reset_n       = 1'b0;
    m_reset_all();
    repeat (3) @(negedge clk);
    a_reset_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_op_ready",     32'(bus.op_ready),     32'd1);
    check("rst_busy",         32'(bus.busy),         32'd0);
    check("rst_data_valid",   32'(bus.data_valid),   32'd0);
    check("rst_data_out",     32'(bus.data_out),     32'd0);
    check("rst_acc_overflow", 32'(bus.acc_overflow), 32'd0);

    // Unsigned MULT/ACC: 200*100 = 0x4E20; ACC stalls two cycles.
    op(MAC_REGA, 0, 8'd200);
    op(MAC_REGB, 0, 8'd100);
    op(MAC_MULT, 0, 0);
    do_op(MAC_ACC, 0, 0, st);
    check("acc_stall_after_mult", 32'(st), 32'd2);
    op(MAC_MSW, 0, 0);
    op(MAC_LSW, 0, 0);

    // Signed MACC: -3*5 = -15.
    op(MAC_RESET, 0, 0);
    op(MAC_REGA, 1, 8'hFD);
    op(MAC_REGB, 1, 8'h05);
    op(MAC_MACC, 1, 0);
    read_all();

    // Streaming: four back-to-back 255*255 MACCs, MSW stalls two cycles.
    op(MAC_RESET, 0, 0);
    op(MAC_REGA, 0, 8'hFF);
    op(MAC_REGB, 0, 8'hFF);
    repeat (4) op(MAC_MACC, 0, 0);
    do_op(MAC_MSW, 0, 0, st);
    check("msw_stall_after_macc", 32'(st), 32'd2);
    op(MAC_LSW, 0, 0);
    op(MAC_GRD, 0, 0);

    // Asynchronous reset in the middle of a MACC, released between edges.
    op(MAC_REGA, 0, 8'd7);
    op(MAC_REGB, 0, 8'd9);
    op(MAC_MACC, 0, 0);
    check("busy_mid_macc", 32'(bus.busy), 32'd1);
    #1 a_reset_n = 1'b0;
    #1;
    check("arst_data_out",     32'(bus.data_out),     32'd0);
    check("arst_data_valid",   32'(bus.data_valid),   32'd0);
    check("arst_acc_overflow", 32'(bus.acc_overflow), 32'd0);
    check("arst_busy",         32'(bus.busy),         32'd0);
    check("arst_op_ready",     32'(bus.op_ready),     32'd1);
    #1 a_reset_n = 1'b1;
    m_reset_all();
    @(negedge clk);
    read_all();

    // Saturation: 17 x 65025 exceeds 20 unsigned bits.
    op(MAC_REGA, 0, 8'hFF);
    op(MAC_REGB, 0, 8'hFF);
    repeat (17) op(MAC_MACC, 0, 0);
    read_all();
    check("sat_overflow_flag", 32'(bus.acc_overflow), 32'd1);
    op(MAC_RESET, 0, 0);
    op(MAC_LSW, 0, 0);
    check("overflow_cleared", 32'(bus.acc_overflow), 32'd0);

    // Flush: RESET on the cycle after MACC wins over its write-back.
    op(MAC_REGA, 1, 8'h80);
    op(MAC_REGB, 1, 8'h7F);
    op(MAC_MACC, 1, 0);
    op(MAC_RESET, 0, 0);
    read_all();
    repeat (2) @(negedge clk);
    check("data_out_hold", 32'(bus.data_out), 32'(m_last_out));

    // Randomized operation stream.
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      sgn = 1'($urandom_range(0, 1));
      if      (r < 4)  o = MAC_RESET;
      else if (r < 20) o = MAC_REGA;
      else if (r < 36) o = MAC_REGB;
      else if (r < 50) o = MAC_MULT;
      else if (r < 58) o = MAC_ACC;
      else if (r < 74) o = MAC_MACC;
      else if (r < 82) o = MAC_MSW;
      else if (r < 88) o = MAC_LSW;
      else if (r < 94) o = MAC_GRD;
      else             o = 4'($urandom_range(9, 15));
      if (o == MAC_ACC) sgn = m_c_sgn;
      op(o, sgn, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
    read_all();

    repeat (4) @(negedge clk);
    check("data_out_hold_end", 32'(bus.data_out), 32'(m_last_out));
    check("readouts_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
